// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard beside ID: tracks in-flight load and
// multi-cycle destinations and stalls ID when no forward can cover it.
module reg_scoreboard #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_id,
  input  logic [REG_W-1:0] rs2_id,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             issue_valid,
  input  logic [REG_W-1:0] issue_rd,
  input  logic             issue_regwrite,
  input  logic             issue_is_load,
  input  logic             issue_is_mc,
  input  logic             mc_done,
  input  logic [REG_W-1:0] mc_rd,
  output logic             stall,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int NREG = 1 << REG_W;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREG-1:0] load_pend;
  logic [NREG-1:0] mc_pend;
  logic [NREG-1:0] load_nxt;
  logic [NREG-1:0] mc_nxt;

  logic rs1_ok;
  logic rs2_ok;
  logic rd_ok;
  logic raw_ld;
  logic raw_mc;
  logic waw_mc;
  logic str_mc;
  logic iss;
  logic trk;

  assign rs1_ok = use_rs1 & (rs1_id != '0);
  assign rs2_ok = use_rs2 & (rs2_id != '0);
  assign rd_ok  = issue_regwrite & (issue_rd != '0);

  assign raw_ld = (rs1_ok & load_pend[rs1_id])
                | (rs2_ok & load_pend[rs2_id]);
  assign raw_mc = (rs1_ok & mc_pend[rs1_id])
                | (rs2_ok & mc_pend[rs2_id]);
  assign waw_mc = issue_valid & rd_ok & mc_pend[issue_rd];
  assign str_mc = issue_valid & issue_is_mc & mc_busy;

  assign stall = raw_ld | raw_mc | waw_mc | str_mc;
  assign iss   = issue_valid & ~stall;
  assign trk   = iss & rd_ok;

  // Load pendency lasts one cycle; a new issue wins over a same-edge clear.
  always_comb begin
    load_nxt = '0;
    mc_nxt   = mc_pend;
    if (mc_done) begin
      mc_nxt[mc_rd] = 1'b0;
    end
    if (trk) begin
      if (issue_is_mc) begin
        mc_nxt[issue_rd] = 1'b1;
      end else if (issue_is_load) begin
        load_nxt[issue_rd] = 1'b1;
      end
    end
    load_nxt[0] = 1'b0;
    mc_nxt[0]   = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend <= '0;
      mc_pend   <= '0;
      mc_busy   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      load_pend <= load_nxt;
      mc_pend   <= mc_nxt;
      mc_busy   <= (mc_busy & ~mc_done) | (trk & issue_is_mc);
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + ONE;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios
// with a queue-based scoreboard fed by a small reference model.
module tb_reg_scoreboard;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] rs1_id;
  logic [REG_W-1:0] rs2_id;
  logic             use_rs1;
  logic             use_rs2;
  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_regwrite;
  logic             issue_is_load;
  logic             issue_is_mc;
  logic             mc_done;
  logic [REG_W-1:0] mc_rd;
  logic             stall;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  reg_scoreboard #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rs1_id(rs1_id),
    .rs2_id(rs2_id),
    .use_rs1(use_rs1),
    .use_rs2(use_rs2),
    .issue_valid(issue_valid),
    .issue_rd(issue_rd),
    .issue_regwrite(issue_regwrite),
    .issue_is_load(issue_is_load),
    .issue_is_mc(issue_is_mc),
    .mc_done(mc_done),
    .mc_rd(mc_rd),
    .stall(stall),
    .mc_busy(mc_busy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bit   m_lp[32];
  bit   m_mp[32];
  bit   m_busy;
  int   m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_lp[i] = 1'b0;
      m_mp[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_cnt  = 0;
  endtask

  function automatic bit m_rd(input bit a[32], input int r);
    return (r == 0) ? 1'b0 : a[r];
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    if (!rst_n) return 1'b0;
    if (use_rs1 && (m_rd(m_lp, rs1_id) || m_rd(m_mp, rs1_id))) s = 1;
    if (use_rs2 && (m_rd(m_lp, rs2_id) || m_rd(m_mp, rs2_id))) s = 1;
    if (issue_valid && issue_regwrite && m_rd(m_mp, issue_rd)) s = 1;
    if (issue_valid && issue_is_mc && m_busy) s = 1;
    return s;
  endfunction

  task automatic m_step(input bit s);
    bit nlp[32];
    for (int i = 0; i < 32; i++) nlp[i] = 1'b0;
    if (mc_done) begin
      m_mp[mc_rd] = 1'b0;
      m_busy      = 1'b0;
    end
    if (issue_valid && !s && issue_regwrite && issue_rd != 0) begin
      if (issue_is_mc) begin
        m_mp[issue_rd] = 1'b1;
        m_busy         = 1'b1;
      end else if (issue_is_load) begin
        nlp[issue_rd] = 1'b1;
      end
    end
    m_lp = nlp;
    if (s && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic drive(input int r1, input bit u1, input int r2,
                       input bit u2, input bit iv, input int rd,
                       input bit rw, input bit ld, input bit mc,
                       input bit dn, input int mrd);
    rs1_id         = REG_W'(r1);
    use_rs1        = u1;
    rs2_id         = REG_W'(r2);
    use_rs2        = u2;
    issue_valid    = iv;
    issue_rd       = REG_W'(rd);
    issue_regwrite = rw;
    issue_is_load  = ld;
    issue_is_mc    = mc;
    mc_done        = dn;
    mc_rd          = REG_W'(mrd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // exp_s < 0 skips the hand-derived stall check for that cycle.
  task automatic tick(input string tag, input int exp_s);
    exp_t e;
    #1;
    e.stall = m_stall();
    e.busy  = m_busy;
    e.cnt   = CNT_W'(m_cnt);
    q.push_back(e);
    if (exp_s >= 0) chk({tag, "_stall"}, 32'(stall), 32'(exp_s));
    e = q.pop_front();
    chk({tag, "_sb_stall"}, 32'(stall), 32'(e.stall));
    chk({tag, "_sb_busy"}, 32'(mc_busy), 32'(e.busy));
    chk({tag, "_sb_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    @(posedge clk);
    if (!rst_n) m_reset();
    else m_step(e.stall);
    @(negedge clk);
  endtask

  int nst;

  initial begin
    rst_n = 1'b0;
    m_reset();
    idle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom, $urandom,
            $urandom);
      tick("rst", 0);
    end
    chk("rst_busy", 32'(mc_busy), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    idle();
    rst_n = 1'b1;
    tick("rel0", 0);
    tick("rel1", 0);
    chk("rel_cnt", 32'(stall_cnt), 0);

    // lw x5 ; add x6,x5,x1
    drive(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    tick("lu_lw", 0);
    drive(5, 1, 1, 1, 1, 6, 1, 0, 0, 0, 0);
    tick("lu_dep", 1);
    tick("lu_go", 0);
    chk("lu_cnt", 32'(stall_cnt), 1);
    drive(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    tick("lu7_lw", 0);
    drive(7, 1, 1, 1, 1, 6, 1, 0, 0, 0, 0);
    tick("lu7_rd", 0);

    drive(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    tick("x0_lw", 0);
    drive(0, 1, 0, 1, 1, 6, 1, 0, 0, 0, 0);
    tick("x0_rd", 0);
    drive(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    tick("nu_lw", 0);
    drive(3, 1, 5, 0, 1, 6, 1, 0, 0, 0, 0);
    tick("nu_rd", 0);

    // back-to-back loads to x5, then stalled load attempt ignored
    drive(0, 0, 0, 0, 1, 5, 1, 1, 0, 0, 0);
    tick("ll_a", 0);
    tick("ll_b", 0);
    drive(5, 1, 0, 0, 1, 8, 1, 1, 0, 0, 0);
    tick("ll_dep", 1);
    tick("ll_go", 0);
    drive(8, 1, 0, 0, 1, 9, 1, 0, 0, 0, 0);
    tick("ll_dep8", 1);
    tick("ll_go8", 0);

    // div x10, reader waits, mc_done after 8 cycles
    drive(0, 0, 0, 0, 1, 10, 1, 0, 1, 0, 0);
    tick("mc_iss", 0);
    nst = 0;
    drive(10, 1, 0, 0, 1, 13, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 9) mc_done = 1'b1;
      if (k == 9) mc_rd = 5'd10;
      chk("mc_busy_hi", 32'(mc_busy), 1);
      #1;
      if (stall) nst++;
      tick("mc_wait", -1);
    end
    chk("mc_nst", 32'(nst), 9);
    mc_done = 1'b0;
    chk("mc_busy_lo", 32'(mc_busy), 0);
    tick("mc_rel", 0);

    // WAW / structural while busy on x10
    idle();
    drive(0, 0, 0, 0, 1, 10, 1, 0, 1, 0, 0);
    tick("ws_div", 0);
    drive(0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0);
    tick("ws_waw", 1);
    drive(0, 0, 0, 0, 1, 11, 1, 0, 1, 0, 0);
    tick("ws_str", 1);
    drive(0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 0);
    tick("ws_ok", 0);
    drive(0, 0, 0, 0, 1, 10, 1, 0, 0, 1, 10);
    tick("ws_done", 1);
    drive(0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 0);
    tick("ws_go", 0);

    // set wins: stray mc_done rd=10 with a fresh div x10 issue
    drive(0, 0, 0, 0, 1, 10, 1, 0, 1, 1, 10);
    tick("hs_iss", 0);
    chk("hs_busy", 32'(mc_busy), 1);
    drive(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick("hs_pend", 1);

    // saturation: keep the reader stalled
    for (int k = 0; k < 20; k++) tick("sat", 1);
    chk("sat_cnt", 32'(stall_cnt), CMAX);
    drive(10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 10);
    tick("sat_done", 1);
    chk("sat_hold", 32'(stall_cnt), CMAX);
    idle();
    tick("sat_idle", 0);

    // async reset mid-operation
    drive(0, 0, 0, 0, 1, 10, 1, 0, 1, 0, 0);
    tick("ar_div", 0);
    drive(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("ar_busy", 32'(mc_busy), 0);
    chk("ar_cnt", 32'(stall_cnt), 0);
    chk("ar_stall", 32'(stall), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick("ar_after", 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
